// File: rtl/axi_llc_write_unit_mq.sv
// axi_llc_write_unit_mq: LLC write unit streaming buffered W beats to the data ways, with per-burst B responses.
// Optional saturating performance counters are enabled by defining AXI_LLC_WRITE_UNIT_PERF_EN.
package axi_llc_wu_pkg;
  localparam int unsigned AddrWidth         = 32;
  localparam int unsigned IdWidth           = 4;
  localparam int unsigned DataWidth         = 64;
  localparam int unsigned StrbWidth         = DataWidth / 8;
  localparam int unsigned ByteOffsetLength  = 3;
  localparam int unsigned BlockOffsetLength = 5;
  localparam int unsigned IndexLength       = 8;
  localparam int unsigned SetAssociativity  = 4;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] WChanUnit  = 2'd2;
  typedef struct packed {
    logic [IdWidth-1:0]          a_x_id;
    logic [AddrWidth-1:0]        a_x_addr;
    logic [7:0]                  a_x_len;
    logic [2:0]                  a_x_size;
    logic [1:0]                  a_x_burst;
    logic [1:0]                  x_resp;
    logic                        x_last;
    logic [SetAssociativity-1:0] way_ind;
  } desc_t;
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;
  typedef struct packed {
    logic [1:0]                   cache_unit;
    logic [SetAssociativity-1:0]  way_ind;
    logic [IndexLength-1:0]       line_addr;
    logic [BlockOffsetLength-1:0] blk_offset;
    logic                         we;
    logic [DataWidth-1:0]         data;
    logic [StrbWidth-1:0]         strb;
  } way_inp_t;
  typedef struct packed {
    logic [IndexLength-1:0]      index;
    logic [SetAssociativity-1:0] way_ind;
  } lock_t;
endpackage

// Registered-output stream FIFO: a pushed entry becomes visible the cycle after the push.
module axi_llc_wu_fifo #(
  parameter int unsigned Depth = 2,
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);
  localparam logic [PtrW:0] CntMax = (PtrW + 1)'(Depth);
  data_t r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [PtrW:0] r_cnt;
  logic w_push, w_pop;
  assign full_o  = r_cnt == CntMax;
  assign empty_o = r_cnt == '0;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_mem[r_wptr] <= data_i;
      if (w_push) r_wptr <= r_wptr == PtrMax ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr == PtrMax ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
    end
  end
endmodule

module axi_llc_write_unit_mq
  import axi_llc_wu_pkg::*;
#(
  parameter int unsigned WBufDepth = 4,
  parameter int unsigned DescDepth = 2,
  parameter int unsigned BDepth    = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     test_i,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  input  w_chan_t  w_chan_slv_i,
  input  logic     w_chan_valid_i,
  output logic     w_chan_ready_o,
  output b_chan_t  b_chan_slv_o,
  output logic     b_chan_valid_o,
  input  logic     b_chan_ready_i,
  output way_inp_t way_inp_o,
  output logic     way_inp_valid_o,
  input  logic     way_inp_ready_i,
  output lock_t    w_unlock_o,
  output logic     w_unlock_req_o,
  input  logic     w_unlock_gnt_i
`ifdef AXI_LLC_WRITE_UNIT_PERF_EN
  ,
  output logic [31:0] perf_beats_o,
  output logic [31:0] perf_drop_o,
  output logic [31:0] perf_stall_o
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_e;
  localparam int unsigned IdxLsb = ByteOffsetLength + BlockOffsetLength;
  state_e r_state, w_state_next;
  desc_t r_desc, w_desc_head;
  w_chan_t w_w_head;
  b_chan_t w_b_data;
  logic [8:0] r_wrap_len;
  logic r_err;
  logic w_desc_empty, w_desc_full, w_w_empty, w_w_full, w_b_empty, w_b_full;
  logic w_last_beat, w_gate, w_fire, w_done, w_load, w_b_push, w_w_valid;
  logic [AddrWidth-1:0] w_nb, w_incr, w_mask, w_next_addr;
  logic w_unused;
  assign w_unused = ^{test_i, w_w_head.last};

  axi_llc_wu_fifo #(.Depth(DescDepth), .data_t(desc_t)) u_desc_fifo (
    .clk_i, .rst_ni, .push_i(desc_valid_i), .data_i(desc_i), .pop_i(w_load),
    .data_o(w_desc_head), .full_o(w_desc_full), .empty_o(w_desc_empty)
  );
  axi_llc_wu_fifo #(.Depth(WBufDepth), .data_t(w_chan_t)) u_w_fifo (
    .clk_i, .rst_ni, .push_i(w_chan_valid_i), .data_i(w_chan_slv_i), .pop_i(w_fire),
    .data_o(w_w_head), .full_o(w_w_full), .empty_o(w_w_empty)
  );
  axi_llc_wu_fifo #(.Depth(BDepth), .data_t(b_chan_t)) u_b_fifo (
    .clk_i, .rst_ni, .push_i(w_b_push), .data_i(w_b_data), .pop_i(b_chan_ready_i),
    .data_o(b_chan_slv_o), .full_o(w_b_full), .empty_o(w_b_empty)
  );

  assign desc_ready_o   = ~w_desc_full;
  assign w_chan_ready_o = ~w_w_full;
  assign b_chan_valid_o = ~w_b_empty;
  assign w_w_valid      = ~w_w_empty;
  assign w_last_beat    = r_desc.a_x_len == '0;
  // Only the closing beat of a whole burst needs room in the B queue.
  assign w_gate = w_unlock_gnt_i & (~w_last_beat | ~r_desc.x_last | ~w_b_full);
  assign way_inp_valid_o = (r_state == WRITE) & w_w_valid & w_gate;
  assign w_fire = (r_state == WRITE) ? way_inp_valid_o & way_inp_ready_i
                                     : (r_state == DROP) & w_w_valid & w_gate;
  assign w_done         = w_fire & w_last_beat;
  assign w_load         = ~w_desc_empty & ((r_state == IDLE) | w_done);
  assign w_unlock_req_o = w_done;
  assign w_b_push       = w_done & r_desc.x_last;
  assign w_b_data = '{id: r_desc.a_x_id,
                      resp: (r_err | r_desc.x_resp == RespSlvErr) ? RespSlvErr : RespOkay};

  assign w_nb   = AddrWidth'(1) << r_desc.a_x_size;
  assign w_incr = (r_desc.a_x_addr + w_nb) & ~(w_nb - AddrWidth'(1));
  assign w_mask = (AddrWidth'(r_wrap_len) << r_desc.a_x_size) - AddrWidth'(1);
  assign w_next_addr = r_desc.a_x_burst == BurstFixed ? r_desc.a_x_addr
                     : r_desc.a_x_burst == BurstWrap  ? (r_desc.a_x_addr & ~w_mask) | (w_incr & w_mask)
                     : w_incr;

  assign way_inp_o = '{cache_unit: WChanUnit, way_ind: r_desc.way_ind,
                       line_addr: r_desc.a_x_addr[IdxLsb +: IndexLength],
                       blk_offset: r_desc.a_x_addr[ByteOffsetLength +: BlockOffsetLength],
                       we: 1'b1, data: w_w_head.data, strb: w_w_head.strb};
  assign w_unlock_o = '{index: r_desc.a_x_addr[IdxLsb +: IndexLength], way_ind: r_desc.way_ind};

  always_comb begin
    w_state_next = r_state;
    if (w_load) w_state_next = w_desc_head.x_resp == RespSlvErr ? DROP : WRITE;
    else if (w_done) w_state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_desc     <= '0;
      r_wrap_len <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_load) begin
        r_desc     <= w_desc_head;
        r_wrap_len <= {1'b0, w_desc_head.a_x_len} + 9'd1;
      end else if (w_fire & ~w_last_beat) begin
        r_desc.a_x_len  <= r_desc.a_x_len - 8'd1;
        r_desc.a_x_addr <= w_next_addr;
      end
      if (w_done) r_err <= r_desc.x_last ? 1'b0 : r_err | (r_desc.x_resp == RespSlvErr);
    end
  end

`ifdef AXI_LLC_WRITE_UNIT_PERF_EN
  logic [31:0] r_perf_beats, r_perf_drop, r_perf_stall;
  logic w_stall;
  assign w_stall      = (r_state != IDLE) & w_w_valid & ~w_gate;
  assign perf_beats_o = r_perf_beats;
  assign perf_drop_o  = r_perf_drop;
  assign perf_stall_o = r_perf_stall;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_beats <= '0;
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_fire & (r_state == WRITE) & ~&r_perf_beats) r_perf_beats <= r_perf_beats + 32'd1;
      if (w_fire & (r_state == DROP) & ~&r_perf_drop) r_perf_drop <= r_perf_drop + 32'd1;
      if (w_stall & ~&r_perf_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_llc_write_unit_mq.sv
// tb_axi_llc_write_unit_mq: randomized scenarios checked against a per-beat closed-form address/response model.
module tb_axi_llc_write_unit_mq;
  import axi_llc_wu_pkg::*;
  logic clk = 1'b0, rst_ni = 1'b0, test_i = 1'b0;
  desc_t desc_i = '0;
  logic desc_valid_i = 1'b0, desc_ready_o;
  w_chan_t w_chan_slv_i = '0;
  logic w_chan_valid_i = 1'b0, w_chan_ready_o;
  b_chan_t b_chan_slv_o;
  logic b_chan_valid_o, b_chan_ready_i = 1'b1;
  way_inp_t way_inp_o;
  logic way_inp_valid_o, way_inp_ready_i = 1'b1;
  lock_t w_unlock_o;
  logic w_unlock_req_o, w_unlock_gnt_i = 1'b1;
`ifdef AXI_LLC_WRITE_UNIT_PERF_EN
  logic [31:0] perf_beats_o, perf_drop_o, perf_stall_o;
`endif

  axi_llc_write_unit_mq #(.WBufDepth(4), .DescDepth(2), .BDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_i(test_i),
    .desc_i(desc_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .w_chan_slv_i(w_chan_slv_i), .w_chan_valid_i(w_chan_valid_i), .w_chan_ready_o(w_chan_ready_o),
    .b_chan_slv_o(b_chan_slv_o), .b_chan_valid_o(b_chan_valid_o), .b_chan_ready_i(b_chan_ready_i),
    .way_inp_o(way_inp_o), .way_inp_valid_o(way_inp_valid_o), .way_inp_ready_i(way_inp_ready_i),
    .w_unlock_o(w_unlock_o), .w_unlock_req_o(w_unlock_req_o), .w_unlock_gnt_i(w_unlock_gnt_i)
`ifdef AXI_LLC_WRITE_UNIT_PERF_EN
    , .perf_beats_o(perf_beats_o), .perf_drop_o(perf_drop_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, unlock_cyc = 0, b_rise_cyc = 0;
  bit rnd = 0, gaps = 0, d_hs = 0, w_hs = 0, b_prev = 0;
  desc_t tx_d[$];
  w_chan_t tx_w[$];
  way_inp_t obs_w[$], exp_w[$];
  b_chan_t obs_b[$], exp_b[$];
  lock_t obs_lk[$], exp_lk[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (d_hs && tx_d.size() != 0) void'(tx_d.pop_front());
    desc_valid_i = tx_d.size() != 0 && (!gaps || $urandom_range(0, 2) != 0);
    desc_i = tx_d.size() != 0 ? tx_d[0] : '0;
    @(negedge clk);
    d_hs = desc_valid_i && desc_ready_o;
  end

  initial forever begin
    @(posedge clk); #1;
    if (w_hs && tx_w.size() != 0) void'(tx_w.pop_front());
    w_chan_valid_i = tx_w.size() != 0 && (!gaps || $urandom_range(0, 2) != 0);
    w_chan_slv_i = tx_w.size() != 0 ? tx_w[0] : '0;
    @(negedge clk);
    w_hs = w_chan_valid_i && w_chan_ready_o;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd) begin
      way_inp_ready_i = $urandom_range(0, 3) != 0;
      b_chan_ready_i  = $urandom_range(0, 2) != 0;
      w_unlock_gnt_i  = $urandom_range(0, 4) != 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (way_inp_valid_o && way_inp_ready_i) obs_w.push_back(way_inp_o);
    if (w_unlock_req_o) begin
      obs_lk.push_back(w_unlock_o);
      unlock_cyc = cyc;
    end
    if (b_chan_valid_o && !b_prev) b_rise_cyc = cyc;
    b_prev = b_chan_valid_o;
    if (b_chan_valid_o && b_chan_ready_i) obs_b.push_back(b_chan_slv_o);
  end

  // Address of beat i straight from the AXI burst rules, no iteration.
  function automatic logic [31:0] beat_addr(desc_t d, int i);
    logic [31:0] nb, tot, base;
    nb = 32'd1 << d.a_x_size;
    tot = ({24'd0, d.a_x_len} + 32'd1) * nb;
    base = d.a_x_addr & ~(tot - 32'd1);
    if (d.a_x_burst == BurstFixed) return d.a_x_addr;
    if (d.a_x_burst == BurstWrap) return base + ((d.a_x_addr - base + 32'(i) * nb) % tot);
    return i == 0 ? d.a_x_addr : (d.a_x_addr & ~(nb - 32'd1)) + 32'(i) * nb;
  endfunction

  function automatic desc_t mk(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [2:0] sz,
                               logic [1:0] br, logic [1:0] rs, logic lst, logic [3:0] way);
    mk = '{a_x_id: id, a_x_addr: a, a_x_len: len, a_x_size: sz, a_x_burst: br,
           x_resp: rs, x_last: lst, way_ind: way};
  endfunction

  task automatic build_expect(input desc_t ds[$], input w_chan_t ws[$]);
    int k;
    bit err;
    logic [31:0] a;
    k = 0;
    err = 0;
    exp_w.delete(); exp_b.delete(); exp_lk.delete();
    foreach (ds[j]) begin
      for (int i = 0; i <= int'(ds[j].a_x_len); i++) begin
        a = beat_addr(ds[j], i);
        if (ds[j].x_resp != RespSlvErr)
          exp_w.push_back('{cache_unit: WChanUnit, way_ind: ds[j].way_ind, line_addr: a[15:8],
                            blk_offset: a[7:3], we: 1'b1, data: ws[k].data, strb: ws[k].strb});
        k++;
      end
      exp_lk.push_back('{index: a[15:8], way_ind: ds[j].way_ind});
      err |= ds[j].x_resp == RespSlvErr;
      if (ds[j].x_last) begin
        exp_b.push_back('{id: ds[j].a_x_id, resp: err ? RespSlvErr : RespOkay});
        err = 0;
      end
    end
  endtask

  task automatic send(input desc_t ds[$]);
    w_chan_t w;
    w_chan_t ws[$];
    int n;
    n = 0;
    foreach (ds[j]) n += int'(ds[j].a_x_len) + 1;
    for (int i = 0; i < n; i++) begin
      w.data = {$urandom, $urandom};
      w.strb = 8'($urandom);
      w.last = i == n - 1;
      ws.push_back(w);
    end
    build_expect(ds, ws);
    foreach (ds[j]) tx_d.push_back(ds[j]);
    foreach (ws[i]) tx_w.push_back(ws[i]);
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_b.delete(); obs_lk.delete();
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (obs_b.size() >= exp_b.size() && obs_lk.size() >= exp_lk.size() && tx_w.size() == 0) begin
        ok = 1;
        repeat (4) @(negedge clk);
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (way_inp_valid_o !== 1'b0 || b_chan_valid_o !== 1'b0 || w_unlock_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got way=%b b=%b unl=%b exp 0", way_inp_valid_o, b_chan_valid_o, w_unlock_req_o);
    end
    checks++;
    if (w_unlock_o !== '0) begin
      errors++;
      $display("FAIL reset_lock got %h exp 0", w_unlock_o);
    end
    @(posedge clk); #1;
    rst_ni = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_incr();
    desc_t ds[$];
    bit ok;
    clear_obs();
    ds.push_back(mk(4'h9, 32'h100, 8'd3, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b0010));
    send(ds);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL incr_timeout got b=%0d exp %0d", obs_b.size(), exp_b.size()); end
    checks++;
    if (obs_w.size() !== 4) begin errors++; $display("FAIL incr_count got %0d exp 4", obs_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      checks++;
      if (obs_w[i] !== exp_w[i] || obs_w[i].blk_offset !== 5'(i) || obs_w[i].line_addr !== 8'h01) begin
        errors++;
        $display("FAIL incr_w[%0d] got %h exp %h", i, obs_w[i], exp_w[i]);
      end
    end
    checks++;
    if (obs_lk.size() !== 1 || b_rise_cyc - unlock_cyc !== 1) begin
      errors++;
      $display("FAIL incr_unlock got n=%0d dt=%0d exp n=1 dt=1", obs_lk.size(), b_rise_cyc - unlock_cyc);
    end
    checks++;
    if (obs_b.size() !== 1 || obs_b[0] !== b_chan_t'({4'h9, RespOkay})) begin
      errors++;
      $display("FAIL incr_b got n=%0d b=%h exp 1 %h", obs_b.size(), obs_b.size() ? obs_b[0] : '0, {4'h9, RespOkay});
    end
  endtask

  task automatic test_wrap();
    desc_t ds[$];
    bit ok;
    logic [4:0] blk [4];
    blk = '{5'd7, 5'd6, 5'd6, 5'd7};
    clear_obs();
    ds.push_back(mk(4'h2, 32'h3C, 8'd3, 3'd2, BurstWrap, RespOkay, 1'b1, 4'b0001));
    send(ds);
    wait_done(ok);
    checks++;
    if (!ok || obs_w.size() !== 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", obs_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      checks++;
      if (obs_w[i] !== exp_w[i] || obs_w[i].blk_offset !== blk[i]) begin
        errors++;
        $display("FAIL wrap_w[%0d] got %h exp %h", i, obs_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_split_err();
    desc_t ds[$];
    bit ok;
    clear_obs();
    ds.push_back(mk(4'h3, 32'h200, 8'd1, 3'd3, BurstIncr, RespSlvErr, 1'b0, 4'b0100));
    ds.push_back(mk(4'h3, 32'h210, 8'd1, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b0100));
    ds.push_back(mk(4'h5, 32'h300, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b1000));
    send(ds);
    wait_done(ok);
    checks++;
    if (!ok || obs_w.size() !== 3) begin errors++; $display("FAIL split_count got %0d exp 3", obs_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL split_w[%0d] got %h exp %h", i, obs_w[i], exp_w[i]); end
    end
    checks++;
    if (obs_b.size() !== 2 || obs_lk.size() !== 3) begin
      errors++;
      $display("FAIL split_nb got b=%0d lk=%0d exp 2 3", obs_b.size(), obs_lk.size());
    end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      checks++;
      if (obs_b[i] !== exp_b[i] || obs_b[i].resp !== (i == 0 ? RespSlvErr : RespOkay)) begin
        errors++;
        $display("FAIL split_b[%0d] got %h exp %h", i, obs_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_b_backpressure();
    desc_t ds[$];
    bit ok;
    clear_obs();
    b_chan_ready_i = 0;
    for (int i = 0; i < 3; i++)
      ds.push_back(mk(4'(i + 10), 32'h400 + 32'(i * 8), 8'd0, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b0001));
    send(ds);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_lk.size() !== 2 || obs_b.size() !== 0 || w_unlock_req_o !== 1'b0 || b_chan_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got lk=%0d b=%0d req=%b bv=%b exp 2 0 0 1",
               obs_lk.size(), obs_b.size(), w_unlock_req_o, b_chan_valid_o);
    end
    @(posedge clk); #1;
    b_chan_ready_i = 1;
    wait_done(ok);
    checks++;
    if (!ok || obs_b.size() !== 3 || obs_lk.size() !== 3) begin
      errors++;
      $display("FAIL bp_done got b=%0d lk=%0d exp 3 3", obs_b.size(), obs_lk.size());
    end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      checks++;
      if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL bp_b[%0d] got %h exp %h", i, obs_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_gnt_stall();
    desc_t ds[$];
    bit ok;
    int n;
    clear_obs();
    ds.push_back(mk(4'h6, 32'h1F0, 8'd7, 3'd2, BurstIncr, RespOkay, 1'b1, 4'b0010));
    send(ds);
    for (int t = 0; t < 200 && obs_w.size() < 3; t++) @(negedge clk);
    @(posedge clk); #1;
    w_unlock_gnt_i = 0;
    @(negedge clk);
    n = obs_w.size();
    repeat (5) @(negedge clk);
    checks++;
    if (obs_w.size() !== n || obs_lk.size() !== 0 || way_inp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got w=%0d lk=%0d v=%b exp %0d 0 0", obs_w.size(), obs_lk.size(), way_inp_valid_o, n);
    end
    @(posedge clk); #1;
    w_unlock_gnt_i = 1;
    wait_done(ok);
    checks++;
    if (!ok || obs_w.size() !== 8) begin errors++; $display("FAIL stall_count got %0d exp 8", obs_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL stall_w[%0d] got %h exp %h", i, obs_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_random();
    desc_t ds[$];
    bit ok;
    logic [2:0] sz;
    logic [1:0] br;
    logic [7:0] len;
    logic [3:0] id;
    int nd;
    rnd = 1;
    gaps = 1;
    for (int r = 0; r < 5; r++) begin
      clear_obs();
      ds.delete();
      for (int b = 0; b < int'($urandom_range(2, 4)); b++) begin
        id = 4'($urandom);
        nd = $urandom_range(1, 3);
        for (int d = 0; d < nd; d++) begin
          br = 2'($urandom_range(0, 2));
          sz = 3'($urandom_range(0, 3));
          len = br == BurstWrap ? 8'((2 << $urandom_range(0, 2)) - 1) : 8'($urandom_range(0, 7));
          ds.push_back(mk(id, ($urandom & 32'hFFFF) & ~((32'd1 << sz) - 32'd1), len, sz, br,
                          $urandom_range(0, 3) == 0 ? RespSlvErr : RespOkay, d == nd - 1,
                          4'b0001 << $urandom_range(0, 3)));
        end
      end
      send(ds);
      wait_done(ok);
      checks++;
      if (!ok || obs_w.size() !== exp_w.size() || obs_lk.size() !== exp_lk.size()) begin
        errors++;
        $display("FAIL rnd%0d_count got w=%0d lk=%0d exp %0d %0d", r, obs_w.size(), obs_lk.size(), exp_w.size(), exp_lk.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
        checks++;
        if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL rnd%0d_w[%0d] got %h exp %h", r, i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_lk[i]) if (i < obs_lk.size()) begin
        checks++;
        if (obs_lk[i] !== exp_lk[i]) begin errors++; $display("FAIL rnd%0d_lk[%0d] got %h exp %h", r, i, obs_lk[i], exp_lk[i]); end
      end
      checks++;
      if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL rnd%0d_nb got %0d exp %0d", r, obs_b.size(), exp_b.size()); end
      foreach (exp_b[i]) if (i < obs_b.size()) begin
        checks++;
        if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL rnd%0d_b[%0d] got %h exp %h", r, i, obs_b[i], exp_b[i]); end
      end
    end
    rnd = 0;
    gaps = 0;
    @(posedge clk); #1;
    way_inp_ready_i = 1;
    b_chan_ready_i = 1;
    w_unlock_gnt_i = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    desc_t ds[$];
    bit ok;
    clear_obs();
    ds.push_back(mk(4'h7, 32'h500, 8'd15, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b0100));
    send(ds);
    for (int t = 0; t < 200 && obs_w.size() < 3; t++) @(negedge clk);
    @(posedge clk); #2;
    rst_ni = 0;
    tx_d.delete();
    tx_w.delete();
    #1;
    checks++;
    if (way_inp_valid_o !== 1'b0 || b_chan_valid_o !== 1'b0 || w_unlock_req_o !== 1'b0 || w_unlock_o !== '0) begin
      errors++;
      $display("FAIL rstmid_out got v=%b bv=%b req=%b lk=%h exp 0 0 0 0", way_inp_valid_o, b_chan_valid_o, w_unlock_req_o, w_unlock_o);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 1;
    repeat (2) @(negedge clk);
    clear_obs();
    ds.delete();
    ds.push_back(mk(4'hC, 32'h640, 8'd1, 3'd3, BurstIncr, RespOkay, 1'b1, 4'b0001));
    send(ds);
    wait_done(ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || obs_b.size() !== 1 || obs_w.size() !== 2) begin
      errors++;
      $display("FAIL rstmid_after got b=%0d w=%0d exp 1 2", obs_b.size(), obs_w.size());
    end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      checks++;
      if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL rstmid_w[%0d] got %h exp %h", i, obs_w[i], exp_w[i]); end
    end
    checks++;
    if (obs_b.size() == 0 || obs_b[0] !== exp_b[0]) begin
      errors++;
      $display("FAIL rstmid_b got %h exp %h", obs_b.size() ? obs_b[0] : '0, exp_b[0]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_split_err();
    test_b_backpressure();
    test_gnt_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
